game_controller_rounds: RTL



---
 rtl/game_controller_rounds.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/game_controller_rounds.sv
// Multi-round whack-a-mole game sequencer: welcome, time load, timed rounds with
// pause, inter-round gap and final score screen, with an internal per-second countdown.
module game_controller_rounds #(
    parameter int NUM_ROUNDS = 3,
    parameter int TIME_W     = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int TIME_DEC   = 2,
    parameter int TIME_MIN   = 1,
    parameter int PAUSE_EN   = 1,
    localparam int RIDX_W    = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              pause,
    input  logic [TIME_W-1:0] time_in,
    output logic              ld_time,
    output logic              play,
    output logic              paused,
    output logic              display_score,
    output logic              round_done,
    output logic              game_over,
    output logic              tick,
    output logic [RIDX_W-1:0] round_idx,
    output logic [TIME_W-1:0] time_left
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);
    localparam logic [TIME_W-1:0] TL_ONE   = TIME_W'(1);
    localparam int unsigned       FLOOR_T  = TIME_MIN + TIME_DEC;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ARM    = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSED = 3'd4,
        S_GAP    = 3'd5,
        S_SCORE  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               go_q, pause_q;
    logic [RIDX_W-1:0]  round_idx_q, round_idx_d;
    logic [TIME_W-1:0]  round_time_q, round_time_d;
    logic [TIME_W-1:0]  time_left_q, time_left_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               round_done_q, round_done_d;
    logic               game_over_q, game_over_d;

    logic go_rise, pause_rise, tick_now, expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            go_q         <= 1'b1;
            pause_q      <= 1'b1;
            round_idx_q  <= '0;
            round_time_q <= '0;
            time_left_q  <= '0;
            tick_cnt_q   <= '0;
            round_done_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_q         <= go;
            pause_q      <= pause;
            round_idx_q  <= round_idx_d;
            round_time_q <= round_time_d;
            time_left_q  <= time_left_d;
            tick_cnt_q   <= tick_cnt_d;
            round_done_q <= round_done_d;
            game_over_q  <= game_over_d;
        end
    end

    always_comb begin
        go_rise      = go & ~go_q;
        pause_rise   = (PAUSE_EN != 0) & pause & ~pause_q;
        tick_now     = (state_q == S_PLAY) && (tick_cnt_q == CNT_MAX);
        expire       = tick_now && (time_left_q == TL_ONE);

        state_d      = state_q;
        round_idx_d  = round_idx_q;
        round_time_d = round_time_q;
        time_left_d  = time_left_q;
        tick_cnt_d   = tick_cnt_q;
        round_done_d = 1'b0;
        game_over_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go_rise) state_d = S_LOAD;
            end
            S_LOAD: begin
                round_time_d = time_in;
                if (go_rise && (time_in != '0)) state_d = S_ARM;
            end
            S_ARM: begin
                time_left_d = round_time_q;
                tick_cnt_d  = '0;
                state_d     = S_PLAY;
            end
            S_PLAY: begin
                // Every PLAY cycle advances the second counter, including the one that pauses.
                if (tick_now) begin
                    tick_cnt_d  = '0;
                    time_left_d = time_left_q - TL_ONE;
                end else begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                end
                if (expire) begin
                    if (round_idx_q == LAST_IDX) begin
                        state_d     = S_SCORE;
                        game_over_d = 1'b1;
                    end else begin
                        state_d      = S_GAP;
                        round_done_d = 1'b1;
                        round_idx_d  = round_idx_q + RIDX_W'(1);
                        if (32'(round_time_q) <= FLOOR_T)
                            round_time_d = TIME_W'(TIME_MIN);
                        else
                            round_time_d = round_time_q - TIME_W'(TIME_DEC);
                    end
                end else if (pause_rise) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (pause_rise) state_d = S_PLAY;
            end
            S_GAP: begin
                if (go_rise) state_d = S_ARM;
            end
            S_SCORE: begin
                if (go_rise) begin
                    state_d      = S_IDLE;
                    round_idx_d  = '0;
                    round_time_d = '0;
                    time_left_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ld_time       = (state_q == S_LOAD);
    assign play          = (state_q == S_PLAY);
    assign paused        = (state_q == S_PAUSED);
    assign display_score = (state_q == S_SCORE);
    assign round_done    = round_done_q;
    assign game_over     = game_over_q;
    assign tick          = tick_now;
    assign round_idx     = round_idx_q;
    assign time_left     = time_left_q;

endmodule
